// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester-side and memory-side buses that
// meet at mem_arbiter.
//   fetch port : i_req, i_addr -> i_ack, i_rdata (read-only)
//   data port  : d_req, d_rwn, d_addr, d_wdata -> d_ack, d_rdata
//   memory     : mem_start, mem_rwn, mem_address, mem_data_in -> memory
//                mem_ready, mem_data_out <- memory
// slave  = the arbiter's view; master = the environment's view
// (requesters and memory together).
interface mem_arbiter_if;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_rwn;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_start;
  logic        mem_rwn;
  logic [7:0]  mem_address;
  logic [15:0] mem_data_in;
  logic        mem_ready;
  logic [15:0] mem_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_ready, mem_data_out,
    output i_ack, i_rdata, d_ack, d_rdata, mem_start, mem_rwn, mem_address, mem_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_ready, mem_data_out,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_start, mem_rwn, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x16 memory between a read-only fetch port and
// a read/write data port. One transaction at a time; data beats fetch
// unless fetch has been passed over STARVE_LIMIT times in a row. A
// watchdog aborts any transaction stuck in WAIT for TIMEOUT cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : requester + memory handshake signals (mem_arbiter_if.slave)
//   busy   : FSM not in IDLE
//   owner  : 0 = fetch, 1 = data; current / last granted port
//   err    : sticky watchdog flag, cleared only by reset
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 3,
  parameter int          TIMEOUT      = 15,
  parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus,
  output logic           busy,
  output logic           owner,
  output logic           err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic          r_i_ack, r_d_ack, r_mem_start, r_mem_rwn;
  logic [7:0]    r_mem_address;
  logic [15:0]   r_mem_data_in, r_i_rdata, r_d_rdata;
  logic          r_busy, r_owner, r_err;

  logic          w_starved, w_data_win, w_first_wait, w_mem_done, w_timeout;
  logic [TW-1:0] w_tmo_nxt;
  logic [15:0]   w_rdata;

  // Fetch is forced through once data has won STARVE_LIMIT times in a row
  // while fetch was waiting.
  assign w_starved    = bus.i_req && (r_starve == SW'(STARVE_LIMIT));
  assign w_data_win   = bus.d_req && !w_starved;
  // r_tmo is zero only on the first WAIT cycle; memory's ready lags start
  // by a cycle, so ready is not trusted there.
  assign w_first_wait = (r_tmo == '0);
  assign w_mem_done   = !w_first_wait && bus.mem_ready;
  assign w_tmo_nxt    = r_tmo + TW'(1);
  assign w_timeout    = (w_tmo_nxt == TW'(TIMEOUT));
  assign w_rdata      = w_mem_done ? bus.mem_data_out : ERR_DATA;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_starve      <= '0;
      r_tmo         <= '0;
      r_i_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_mem_start   <= 1'b0;
      r_mem_rwn     <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_busy        <= 1'b0;
      r_owner       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((bus.i_req || bus.d_req) && bus.mem_ready) begin
            r_state     <= S_ISSUE;
            r_mem_start <= 1'b1;   // high for the single ISSUE cycle
            r_busy      <= 1'b1;
            r_tmo       <= '0;
            r_owner     <= w_data_win;
            if (w_data_win) begin
              r_mem_address <= bus.d_addr;
              r_mem_rwn     <= bus.d_rwn;
              r_mem_data_in <= bus.d_wdata;
              if (!bus.i_req)
                r_starve <= '0;
              else if (r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + SW'(1);
            end else begin
              r_mem_address <= bus.i_addr;
              r_mem_rwn     <= 1'b1;
              r_mem_data_in <= '0;
              r_starve      <= '0;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_tmo <= w_tmo_nxt;
          // A genuine completion wins over a watchdog expiry on the same cycle.
          if (w_mem_done || w_timeout) begin
            r_state <= S_DONE;
            if (!w_mem_done) r_err <= 1'b1;
            // Ack and read data are registered here so both are valid
            // together throughout the DONE cycle.
            if (r_owner) r_d_ack <= 1'b1;
            else         r_i_ack <= 1'b1;
            if (r_mem_rwn) begin
              if (r_owner) r_d_rdata <= w_rdata;
              else         r_i_rdata <= w_rdata;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.i_ack       = r_i_ack;
  assign bus.d_ack       = r_d_ack;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.mem_start   = r_mem_start;
  assign bus.mem_rwn     = r_mem_rwn;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign busy            = r_busy;
  assign owner           = r_owner;
  assign err             = r_err;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit, 256-word `memory` block between two requesters: an instruction-fetch port (read-only) and a data port (read/write).
- Sits between the control unit's fetch/load-store sequencing and the memory's start/ready handshake.
- Serialises requests and applies data-over-fetch priority with a starvation guard.
- Adds a watchdog so a stuck memory cannot hang the CPU.

Parameters:
STARVE_LIMIT, 3, max consecutive data-port grants while fetch is pending before fetch is forced to win.
TIMEOUT, 15, max cycles in WAIT before the transaction is aborted.
ERR_DATA, 16'hDEAD, value returned on rdata for an aborted read.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
i_req  in  1  fetch request; held high until i_ack.
i_addr  in  8  fetch address.
i_ack  out  1  one-cycle pulse: fetch transaction complete.
i_rdata  out  16  fetched word; valid on i_ack, held until next fetch ack.
d_req  in  1  data request; held high until d_ack.
d_rwn  in  1  1 = read, 0 = write.
d_addr  in  8  data address.
d_wdata  in  16  write data.
d_ack  out  1  one-cycle pulse: data transaction complete.
d_rdata  out  16  read word; valid on d_ack, held until next data read ack.
mem_start  out  1  start strobe to memory.
mem_rwn  out  1  read/write to memory.
mem_address  out  8  address to memory.
mem_data_in  out  16  write data to memory.
mem_ready  in  1  memory idle/complete (high = idle).
mem_data_out  in  16  memory read data.
busy  out  1  high in any state except IDLE.
owner  out  1  0 = fetch, 1 = data; current/last granted port.
err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - All outputs become 0: i_ack, d_ack, mem_start, mem_rwn, mem_address, mem_data_in, i_rdata, d_rdata, busy, owner, err.
  - Starve counter and timeout counter are cleared.
  - Reset mid-transaction abandons the transaction with no ack. The memory is reset on the same line by the top level.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitration runs when (i_req|d_req) && mem_ready.
  - Winner is data if d_req && !(i_req && starve==STARVE_LIMIT); otherwise fetch.
  - The winner's addr, rwn and wdata are latched into mem_address, mem_rwn and mem_data_in. For fetch, mem_rwn=1 and mem_data_in=0.
  - owner is set to the winner; next state is ISSUE.
  - If mem_ready is low, the FSM stays in IDLE.
- ISSUE: mem_start=1 for exactly this one cycle; next state is WAIT.
- WAIT:
  - Memory drops ready the cycle after start.
  - The FSM leaves WAIT on the first cycle with mem_ready==1, counted from the second WAIT cycle. The first WAIT cycle ignores mem_ready because of the one-cycle lag.
  - Next state is DONE.
  - The timeout counter increments each WAIT cycle. If it reaches TIMEOUT: err=1, the FSM goes to DONE as an abort, and a read returns ERR_DATA.
- DONE:
  - Pulse the winner's ack for one cycle.
  - On a read, capture mem_data_out (or ERR_DATA on abort) into the winner's rdata.
  - A write leaves rdata unchanged.
  - Next state is IDLE. Arbitration resumes the following cycle, so there is a minimum one-cycle gap between ISSUE strobes.
- Starve counter:
  - Increments when data wins while i_req is high, saturating at STARVE_LIMIT.
  - Clears when fetch wins, or when data wins with i_req low.
- Latency: req at IDLE to ack = 1 (IDLE) + 1 (ISSUE) + memory time + 1 (DONE). Memory time is 2 + address[1:0] cycles, so the total is 5..8 cycles.
- Request dropped before ack: the transaction still completes and the ack still pulses. The requester must ignore it.
- New request inputs are ignored outside IDLE. Addresses are taken modulo 256 and no wrap logic is needed.

Test Plan:
1. Fetch only, i_addr=8'h00, memory preloaded 16'hA141:
   - i_ack pulses once; i_rdata=16'hA141; mem_start high exactly one cycle.
   - Cycles from i_req to i_ack = 5.
2. Data write then read at address 8'hF7 (address[1:0]=3), d_wdata=16'h1234:
   - Write d_ack arrives after 8 cycles.
   - Read returns d_rdata=16'h1234; i_rdata unchanged.
3. i_req and d_req both held high continuously:
   - Grant order is D,D,D,F,D,D,D,F…
   - owner toggles accordingly; no two mem_start pulses are closer than the minimum gap.
4. Memory model with ready stuck low after start, d_rwn=1:
   - After TIMEOUT WAIT cycles, d_ack pulses, d_rdata=16'hDEAD, err=1.
   - err stays 1 through later good transactions until reset.
5. Reset low during WAIT:
   - Next edge: busy=0, no ack, all outputs 0.
   - After release, a fetch to 8'h02 returns the correct word.
6. d_req deasserted one cycle after grant:
   - Write still lands in memory and d_ack still pulses.
   - A pending i_req is served next.
